// File: rtl/disp_pkg.sv
// Shared definitions for the LED matrix display scheduler.
// Holds the grant/glyph encoding, the matrix geometry and the glyph
// bitmaps. It also holds the round-robin pick used by the arbiter.
package disp_pkg;

    localparam int N_COLS = 5;
    localparam int N_ROWS = 7;

    // A grant code doubles as the glyph code shown on the matrix.
    typedef enum logic [1:0] {
        GLY_NONE = 2'd0,
        GLY_A    = 2'd1,
        GLY_C    = 2'd2,
        GLY_R    = 2'd3
    } glyph_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    // Column 0 sits in the low 7 bits. Bit 0 of each column is the top row.
    localparam logic [N_COLS*N_ROWS-1:0] GLYPH_A_BITS = {7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E};
    localparam logic [N_COLS*N_ROWS-1:0] GLYPH_C_BITS = {7'h22, 7'h41, 7'h41, 7'h41, 7'h3E};
    localparam logic [N_COLS*N_ROWS-1:0] GLYPH_R_BITS = {7'h46, 7'h29, 7'h19, 7'h09, 7'h7F};

    // Returns the first active requester after ptr, in the order A -> C -> R -> A.
    // req bit 0 = A, bit 1 = C, bit 2 = R. Returns GLY_NONE when nothing is active.
    function automatic glyph_e rr_pick(input glyph_e ptr, input logic [2:0] req);
        glyph_e pick;
        pick = GLY_NONE;
        case (ptr)
            GLY_A: begin
                if      (req[1]) pick = GLY_C;
                else if (req[2]) pick = GLY_R;
                else if (req[0]) pick = GLY_A;
            end
            GLY_C: begin
                if      (req[2]) pick = GLY_R;
                else if (req[0]) pick = GLY_A;
                else if (req[1]) pick = GLY_C;
            end
            default: begin
                if      (req[0]) pick = GLY_A;
                else if (req[1]) pick = GLY_C;
                else if (req[2]) pick = GLY_R;
            end
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/glyph_rom.sv
// Combinational glyph lookup.
// Ports:
//   glyph   - glyph code (GLY_NONE/A/C/R)
//   col_idx - matrix column 0..4
//   linha   - 7-bit row pattern for that column, active-high, bit 0 = top row
module glyph_rom
    import disp_pkg::*;
(
    input  glyph_e            glyph,
    input  logic [2:0]        col_idx,
    output logic [N_ROWS-1:0] linha
);

    logic [N_COLS*N_ROWS-1:0] bits;

    always_comb begin
        bits = '0;
        case (glyph)
            GLY_A:   bits = GLYPH_A_BITS;
            GLY_C:   bits = GLYPH_C_BITS;
            GLY_R:   bits = GLYPH_R_BITS;
            default: bits = '0;
        endcase

        linha = '0;
        case (col_idx)
            3'd0:    linha = bits[6:0];
            3'd1:    linha = bits[13:7];
            3'd2:    linha = bits[20:14];
            3'd3:    linha = bits[27:21];
            3'd4:    linha = bits[34:28];
            default: linha = '0;
        endcase
    end

endmodule

// File: rtl/matrix_display_scheduler.sv
// Time-shares the 5x7 LED matrix between the supply (A), consumption (C)
// and restriction (R) status requesters. The matrix is scanned one column
// at a time. The grant rotates round-robin at frame boundaries. The block
// also drives the alarm, which a push button can mute.
// Ports:
//   clk, reset             - single clock, synchronous active-high reset
//   req_a, req_c, req_r    - level requests from the status blocks
//   button                 - mute button, asynchronous to clk
//   COLUNA                 - one-hot active-low column select (registered)
//   LINHA                  - row data for the selected column (registered)
//   alarme                 - alarm output (registered)
//
// state   | meaning
// IDLE    | nothing granted, matrix scans blank, waiting for a request at frame end
// SHOW    | grant_q owns the matrix; re-arbitrated at frame end on slot expiry or drop
module matrix_display_scheduler
    import disp_pkg::*;
#(
    parameter int SCAN_DIV    = 4,
    parameter int SLOT_FRAMES = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_c,
    input  logic              req_r,
    input  logic              button,
    output logic [N_COLS-1:0] COLUNA,
    output logic [N_ROWS-1:0] LINHA,
    output logic              alarme
);

    logic [CNT_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [2:0]        col_idx_q, col_idx_d;
    state_e            state_q, state_d;
    glyph_e            grant_q, grant_d;
    glyph_e            rr_ptr_q, rr_ptr_d;
    logic [N_COLS-1:0] coluna_q, coluna_d;
    logic [N_ROWS-1:0] linha_q, linha_d;
    logic              alarme_q, alarme_d;
    logic              muted_q, muted_d;
    logic              btn_s1_q, btn_s2_q, btn_prev_q;

    logic              tick;
    logic              frame_end;
    logic              btn_rise;
    logic              granted_active;
    logic [2:0]        req_vec;
    glyph_e            pick;
    logic [N_ROWS-1:0] rom_linha;

    glyph_rom u_glyph_rom (
        .glyph   (grant_q),
        .col_idx (col_idx_q),
        .linha   (rom_linha)
    );

    assign req_vec  = {req_r, req_c, req_a};
    assign pick     = rr_pick(rr_ptr_q, req_vec);
    assign btn_rise = btn_s2_q & ~btn_prev_q;

    always_comb begin
        tick        = (div_q == CNT_W'(SCAN_DIV - 1));
        frame_end   = tick && (col_idx_q == 3'(N_COLS - 1));
        div_d       = tick ? '0 : div_q + 1'b1;
        col_idx_d   = col_idx_q;
        if (tick) begin
            col_idx_d = (col_idx_q == 3'(N_COLS - 1)) ? 3'd0 : col_idx_q + 3'd1;
        end
    end

    always_comb begin
        case (grant_q)
            GLY_A:   granted_active = req_a;
            GLY_C:   granted_active = req_c;
            GLY_R:   granted_active = req_r;
            default: granted_active = 1'b0;
        endcase
    end

    // Arbiter: decisions are taken only on frame_end, so the grant never
    // changes in the middle of a frame.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = GLY_NONE;
                if (frame_end && (|req_vec)) begin
                    grant_d     = pick;
                    rr_ptr_d    = pick;
                    frame_cnt_d = '0;
                    state_d     = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (frame_end) begin
                    if ((frame_cnt_q == CNT_W'(SLOT_FRAMES - 1)) || !granted_active) begin
                        frame_cnt_d = '0;
                        if (|req_vec) begin
                            grant_d  = pick;
                            rr_ptr_d = pick;
                        end else begin
                            grant_d = GLY_NONE;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GLY_NONE;
            end
        endcase
    end

    // A dropped req_a clears the mute, even in the same cycle as a press.
    always_comb begin
        muted_d = muted_q;
        if (!req_a) begin
            muted_d = 1'b0;
        end else if (btn_rise) begin
            muted_d = 1'b1;
        end
        alarme_d = req_a & ~muted_d;
        coluna_d = ~(N_COLS'(1) << col_idx_q);
        linha_d  = rom_linha;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            frame_cnt_q <= '0;
            col_idx_q   <= 3'd0;
            state_q     <= ST_IDLE;
            grant_q     <= GLY_NONE;
            rr_ptr_q    <= GLY_R;
            coluna_q    <= '1;
            linha_q     <= '0;
            alarme_q    <= 1'b0;
            muted_q     <= 1'b0;
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            btn_prev_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            frame_cnt_q <= frame_cnt_d;
            col_idx_q   <= col_idx_d;
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            coluna_q    <= coluna_d;
            linha_q     <= linha_d;
            alarme_q    <= alarme_d;
            muted_q     <= muted_d;
            btn_s1_q    <= button;
            btn_s2_q    <= btn_s1_q;
            btn_prev_q  <= btn_s2_q;
        end
    end

    assign COLUNA = coluna_q;
    assign LINHA  = linha_q;
    assign alarme = alarme_q;

endmodule
